// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared counter type, default widths and the 2-bit saturating update
package branch_predictor_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int INDEX_BITS_DEF = 6;
    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } counter_t;
    function automatic counter_t sat_update(input counter_t c, input logic taken);
        return taken ? (c == STRONG_T  ? STRONG_T  : counter_t'(c + 2'd1))
                     : (c == STRONG_NT ? STRONG_NT : counter_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped tagged target store, combinational read, synchronous write
//   clk, reset          : clock, synchronous active-high reset (clears valid bits only)
//   rd_idx, rd_tag      : lookup index/tag; hit when entry valid and tag matches
//   rd_target           : stored target of the indexed entry
//   wr_en, wr_idx, wr_tag, wr_target : write port, overwrites the indexed entry
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  hit,
    output logic [XLEN-1:0]       rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [XLEN-1:0]       wr_target
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    logic [ENTRIES-1:0] valid;
    logic [TAG_BITS-1:0] tag_mem [ENTRIES];
    logic [XLEN-1:0] target_mem [ENTRIES];

    assign hit       = valid[rd_idx] && tag_mem[rd_idx] == rd_tag;
    assign rd_target = target_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    end

    // tags/targets need no reset: they are ignored while the valid bit is clear
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit counters plus BTB, combinational fetch lookup, trained by the evaluator
//   clk, reset                      : clock, synchronous active-high reset
//   fetch_pc                        : PC being fetched
//   predict_taken/target/hit        : zero-latency prediction for fetch_pc
//   update_valid/pc/taken/target    : resolved branch report, applied on the next rising edge
//   update_mispredict               : counted into mispredict_count when update_valid
//   mispredict_count                : saturating misprediction count
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF,
    parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    output logic            predict_hit,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_mispredict,
    output logic [31:0]     mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    counter_t bht [ENTRIES];
    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [XLEN-1:0] btb_target;

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign u_idx = update_pc[INDEX_BITS+1:2];

    branch_target_buffer #(.XLEN(XLEN), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (f_idx),
        .rd_tag    (fetch_pc[XLEN-1:INDEX_BITS+2]),
        .hit       (predict_hit),
        .rd_target (btb_target),
        .wr_en     (update_valid && update_taken),
        .wr_idx    (u_idx),
        .wr_tag    (update_pc[XLEN-1:INDEX_BITS+2]),
        .wr_target (update_target)
    );

    assign predict_taken  = predict_hit && bht[f_idx][1];
    assign predict_target = predict_taken ? btb_target : fetch_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= WEAK_NT;
            mispredict_count <= '0;
        end else if (update_valid) begin
            bht[u_idx] <= sat_update(bht[u_idx], update_taken);
            if (update_mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule
